// File: rtl/sys_defs.sv
// Shared definitions for the issue stage.
//   - fu_class_t  : functional-unit class carried by each reservation-station entry
//   - fu_select_t : concrete unit a grant is routed to
//   - RS_LOG      : log2 of the default reservation-station depth
//   - MULT_LAT_DEF: default number of cycles a multiplier stays occupied
package sys_defs;

    localparam int RS_LOG       = 4;
    localparam int MULT_LAT_DEF = 4;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_LS     = 2'd1,
        CLS_MULT   = 2'd2,
        CLS_BRANCH = 2'd3
    } fu_class_t;

    typedef enum logic [2:0] {
        ALU_1  = 3'd0,
        ALU_2  = 3'd1,
        ALU_3  = 3'd2,
        LS_1   = 3'd3,
        LS_2   = 3'd4,
        MULT_1 = 3'd5,
        MULT_2 = 3'd6,
        BRANCH = 3'd7
    } fu_select_t;

endpackage

// File: rtl/rr_pick3.sv
// Round-robin picker: scans the reservation station starting at rr_ptr
// (wrapping modulo RS_SIZE) and selects the first three entries whose class
// still has capacity left after the entries picked before them.
// Ports:
//   enable     : when low nothing is picked
//   req_valid  : per-entry ready-to-issue
//   req_class  : per-entry class, 2 bits each
//   rr_ptr     : scan start position
//   cap        : per-class capacity this cycle, 2 bits each, indexed by class code
//   pick_valid : slot s holds a pick
//   pick_idx   : entry index per slot
//   pick_cls   : class per slot
//   pick_nth   : how many earlier slots already took this class (0-based)
module rr_pick3 #(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = $clog2(RS_SIZE)
) (
    input  logic                 enable,
    input  logic [RS_SIZE-1:0]   req_valid,
    input  logic [2*RS_SIZE-1:0] req_class,
    input  logic [IDX_W-1:0]     rr_ptr,
    input  logic [7:0]           cap,
    output logic [2:0]           pick_valid,
    output logic [3*IDX_W-1:0]   pick_idx,
    output logic [5:0]           pick_cls,
    output logic [5:0]           pick_nth
);

    logic [1:0]       used [4];
    logic [1:0]       count;
    logic [IDX_W-1:0] idx;
    logic [1:0]       cls;
    int               pos;

    // Walking the entries in rotated order and writing picks back with their
    // real index is the rotate / pick / un-rotate in one pass. Skipping an
    // entry whose class is exhausted lets later entries of other classes through.
    always_comb begin
        pick_valid = '0;
        pick_idx   = '0;
        pick_cls   = '0;
        pick_nth   = '0;
        for (int c = 0; c < 4; c++) used[c] = '0;
        count = '0;
        idx   = '0;
        cls   = '0;
        pos   = 0;
        for (int k = 0; k < RS_SIZE; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= RS_SIZE) pos = pos - RS_SIZE;
            idx = pos[IDX_W-1:0];
            cls = req_class[2*idx +: 2];
            if (enable && count != 2'd3 && req_valid[idx] && used[cls] < cap[2*cls +: 2]) begin
                pick_valid[count]              = 1'b1;
                pick_idx[IDX_W*count +: IDX_W] = idx;
                pick_cls[2*count +: 2]         = cls;
                pick_nth[2*count +: 2]         = used[cls];
                used[cls]                      = used[cls] + 2'd1;
                count                          = count + 2'd1;
            end
        end
    end

endmodule

// File: rtl/fu_issue_arbiter.sv
// Functional-unit issue arbiter. Each cycle grants up to three ready
// reservation-station entries, round-robin from rr_ptr, onto free units:
// three ALUs and one branch unit (no occupancy), two load/store units (busy
// until ls_done) and two multipliers (busy for MULT_LAT cycles).
// Handshake: req_valid[i] is a request; grant[i] high in the same cycle means
// entry i was taken and the RS must drop it before the next edge.
// Ports:
//   clock, reset (async, active low)
//   req_valid[RS_SIZE], req_class[2*RS_SIZE] : requests and their classes
//   ls_done[2]  : load/store unit k completes, free from next cycle
//   squash      : flush; no grants this cycle, LS/MULT freed at the edge
//   issue_valid[3], issue_idx[3*IDX_W], issue_fu[3*3] : per-slot grant info
//   grant[RS_SIZE] : mask of entries issued this cycle
module fu_issue_arbiter
    import sys_defs::*;
#(
    parameter int RS_SIZE  = 2**RS_LOG,
    parameter int MULT_LAT = MULT_LAT_DEF,
    localparam int IDX_W   = $clog2(RS_SIZE),
    localparam int CNT_W   = $clog2(MULT_LAT + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [RS_SIZE-1:0]   req_valid,
    input  logic [2*RS_SIZE-1:0] req_class,
    input  logic [1:0]           ls_done,
    input  logic                 squash,
    output logic [2:0]           issue_valid,
    output logic [3*IDX_W-1:0]   issue_idx,
    output logic [8:0]           issue_fu,
    output logic [RS_SIZE-1:0]   grant
);

    logic [IDX_W-1:0] rr_ptr;
    logic [1:0]       ls_busy;
    logic [CNT_W-1:0] mult_cnt [2];
    logic [1:0]       mult_busy;
    logic [1:0]       ls_free_n;
    logic [1:0]       mult_free_n;
    logic [7:0]       cap;

    logic [2:0]         pick_valid;
    logic [3*IDX_W-1:0] pick_idx;
    logic [5:0]         pick_cls;
    logic [5:0]         pick_nth;

    logic [1:0]       ls_take;
    logic [1:0]       mult_take;
    logic             any_grant;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] next_ptr;
    logic [1:0]       s_cls;
    logic [1:0]       s_nth;
    logic [IDX_W-1:0] s_idx;
    logic             s_u;
    fu_select_t       s_fu;

    assign mult_busy   = {mult_cnt[1] != '0, mult_cnt[0] != '0};
    assign ls_free_n   = 2'(!ls_busy[0]) + 2'(!ls_busy[1]);
    assign mult_free_n = 2'(!mult_busy[0]) + 2'(!mult_busy[1]);
    // Capacity by class code: BRANCH, MULT, LS, ALU.
    assign cap         = {2'd1, mult_free_n, ls_free_n, 2'd3};

    rr_pick3 #(
        .RS_SIZE (RS_SIZE),
        .IDX_W   (IDX_W)
    ) u_pick (
        .enable     (!squash),
        .req_valid  (req_valid),
        .req_class  (req_class),
        .rr_ptr     (rr_ptr),
        .cap        (cap),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx),
        .pick_cls   (pick_cls),
        .pick_nth   (pick_nth)
    );

    // Map each pick to a concrete unit. The nth pick of a class gets the nth
    // free unit of that class, so the lowest-numbered free unit goes first.
    always_comb begin
        issue_valid = '0;
        issue_idx   = '0;
        issue_fu    = '0;
        grant       = '0;
        ls_take     = '0;
        mult_take   = '0;
        any_grant   = 1'b0;
        last_idx    = rr_ptr;
        s_cls       = '0;
        s_nth       = '0;
        s_idx       = '0;
        s_u         = 1'b0;
        s_fu        = ALU_1;
        for (int s = 0; s < 3; s++) begin
            if (pick_valid[s]) begin
                s_cls = pick_cls[2*s +: 2];
                s_nth = pick_nth[2*s +: 2];
                s_idx = pick_idx[IDX_W*s +: IDX_W];
                s_u   = 1'b0;
                case (s_cls)
                    CLS_ALU: s_fu = (s_nth == 2'd0) ? ALU_1 : ((s_nth == 2'd1) ? ALU_2 : ALU_3);
                    CLS_LS: begin
                        s_u          = (s_nth != 2'd0) || ls_busy[0];
                        s_fu         = s_u ? LS_2 : LS_1;
                        ls_take[s_u] = 1'b1;
                    end
                    CLS_MULT: begin
                        s_u            = (s_nth != 2'd0) || mult_busy[0];
                        s_fu           = s_u ? MULT_2 : MULT_1;
                        mult_take[s_u] = 1'b1;
                    end
                    default: s_fu = BRANCH;
                endcase
                issue_valid[s]                  = 1'b1;
                issue_idx[IDX_W*s +: IDX_W]     = s_idx;
                issue_fu[3*s +: 3]              = s_fu;
                grant[s_idx]                    = 1'b1;
                any_grant                       = 1'b1;
                last_idx                        = s_idx;
            end
        end
    end

    assign next_ptr = (last_idx == IDX_W'(RS_SIZE - 1)) ? '0 : last_idx + IDX_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            ls_busy     <= '0;
            mult_cnt[0] <= '0;
            mult_cnt[1] <= '0;
        end else if (squash) begin
            // Squash also overrides a same-cycle ls_done; rr_ptr holds.
            ls_busy     <= '0;
            mult_cnt[0] <= '0;
            mult_cnt[1] <= '0;
        end else begin
            if (any_grant) rr_ptr <= next_ptr;
            // A busy unit cannot be granted, so done and take never collide.
            ls_busy <= (ls_busy & ~ls_done) | ls_take;
            for (int u = 0; u < 2; u++) begin
                if (mult_take[u])
                    mult_cnt[u] <= CNT_W'(MULT_LAT - 1);
                else if (mult_cnt[u] != '0)
                    mult_cnt[u] <= mult_cnt[u] - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Directed bench for fu_issue_arbiter with default parameters (16 entries,
// MULT_LAT 4). Inputs change just after the falling edge; the combinational
// grant outputs are sampled 2 time units later, before the next rising edge.
module tb_fu_issue_arbiter;

    localparam int A1 = 0, A2 = 1, A3 = 2, L1 = 3, L2 = 4, M1 = 5, M2 = 6, BR = 7;
    localparam int C_ALU = 0, C_LS = 1, C_MULT = 2, C_BR = 3;

    logic        clock;
    logic        reset;
    logic [15:0] req_valid;
    logic [31:0] req_class;
    logic [1:0]  ls_done;
    logic        squash;
    logic [2:0]  issue_valid;
    logic [11:0] issue_idx;
    logic [8:0]  issue_fu;
    logic [15:0] grant;

    logic [39:0] exp_q[$];
    int          n_cmp;
    int          n_fail;

    fu_issue_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_class   (req_class),
        .ls_done     (ls_done),
        .squash      (squash),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .issue_fu    (issue_fu),
        .grant       (grant)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Expected output vector {issue_valid, issue_idx, issue_fu, grant} for n slots.
    function automatic logic [39:0] mk3(input int n, input int i0, input int f0,
                                        input int i1, input int f1, input int i2, input int f2);
        logic [2:0]  v;
        logic [11:0] ix;
        logic [8:0]  fu;
        logic [15:0] g;
        int          ia[3];
        int          fa[3];
        ia = '{i0, i1, i2};
        fa = '{f0, f1, f2};
        v = '0; ix = '0; fu = '0; g = '0;
        for (int s = 0; s < n; s++) begin
            v[s]          = 1'b1;
            ix[4*s +: 4]  = ia[s][3:0];
            fu[3*s +: 3]  = fa[s][2:0];
            g[ia[s]]      = 1'b1;
        end
        return {v, ix, fu, g};
    endfunction

    // driver tasks
    task automatic set_req(input int i, input int c);
        req_valid[i]       = 1'b1;
        req_class[2*i +: 2] = c[1:0];
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic push_exp(input logic [39:0] e);
        exp_q.push_back(e);
    endtask

    // scoreboard: pop the expectation for this cycle and compare, then advance.
    task automatic cyc(input string tag);
        logic [39:0] exp_v;
        logic [39:0] obs_v;
        #2;
        exp_v = exp_q.pop_front();
        obs_v = {issue_valid, issue_idx, issue_fu, grant};
        n_cmp++;
        assert (obs_v === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs_v, exp_v);
        end
        @(negedge clock);
    endtask

    task automatic do_reset(input string tag);
        req_valid = '0;
        ls_done   = '0;
        squash    = 1'b0;
        reset     = 1'b0;
        push_exp(mk3(0, 0, 0, 0, 0, 0, 0));
        cyc(tag);
        reset = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b0; req_valid = '0; req_class = '0; ls_done = '0; squash = 1'b0;
        @(negedge clock);
        do_reset("reset_state");

        // Five ALU requests from rr_ptr 0
        for (int i = 0; i < 5; i++) set_req(i, C_ALU);
        push_exp(mk3(3, 0, A1, 1, A2, 2, A3)); cyc("alu5_c0");
        for (int i = 0; i < 3; i++) clr_req(i);
        push_exp(mk3(2, 3, A1, 4, A2, 0, 0)); cyc("alu5_c1");
        clr_req(3); clr_req(4);
        push_exp(mk3(0, 0, 0, 0, 0, 0, 0)); cyc("alu5_idle");

        // Wrap: steer rr_ptr to 14, then requests at 15,0,1
        do_reset("rst_wrap");
        set_req(13, C_ALU);
        push_exp(mk3(1, 13, A1, 0, 0, 0, 0)); cyc("wrap_setup");
        clr_req(13);
        set_req(15, C_ALU); set_req(0, C_ALU); set_req(1, C_ALU);
        push_exp(mk3(3, 15, A1, 0, A2, 1, A3)); cyc("wrap_order");
        clr_req(15); clr_req(0);
        set_req(2, C_ALU);
        push_exp(mk3(2, 2, A1, 1, A2, 0, 0)); cyc("wrap_ptr2");
        clr_req(1); clr_req(2);

        // Multiplier occupancy
        do_reset("rst_mult");
        set_req(2, C_MULT); set_req(5, C_MULT); set_req(9, C_MULT);
        push_exp(mk3(2, 2, M1, 5, M2, 0, 0)); cyc("mult_c0");
        clr_req(2); clr_req(5);
        for (int k = 1; k <= 3; k++) begin
            push_exp(mk3(0, 0, 0, 0, 0, 0, 0)); cyc($sformatf("mult_wait%0d", k));
        end
        push_exp(mk3(1, 9, M1, 0, 0, 0, 0)); cyc("mult_c4");
        clr_req(9);

        // Load/store occupancy
        do_reset("rst_ls");
        set_req(0, C_LS); set_req(1, C_LS); set_req(2, C_LS);
        push_exp(mk3(2, 0, L1, 1, L2, 0, 0)); cyc("ls_c0");
        clr_req(0); clr_req(1);
        for (int k = 1; k <= 4; k++) begin
            push_exp(mk3(0, 0, 0, 0, 0, 0, 0)); cyc($sformatf("ls_wait%0d", k));
        end
        ls_done = 2'b10;
        push_exp(mk3(0, 0, 0, 0, 0, 0, 0)); cyc("ls_done_c5");
        ls_done = 2'b00;
        push_exp(mk3(1, 2, L2, 0, 0, 0, 0)); cyc("ls_c6");
        clr_req(2);
        set_req(3, C_LS); ls_done = 2'b01;
        push_exp(mk3(0, 0, 0, 0, 0, 0, 0)); cyc("ls_c7");
        ls_done = 2'b00;
        push_exp(mk3(1, 3, L1, 0, 0, 0, 0)); cyc("ls_c8");
        clr_req(3);

        // Branch capacity of one, no head-of-line blocking
        do_reset("rst_br");
        set_req(3, C_BR); set_req(4, C_BR); set_req(5, C_ALU);
        push_exp(mk3(2, 3, BR, 5, A1, 0, 0)); cyc("br_c0");
        clr_req(3); clr_req(5);
        push_exp(mk3(1, 4, BR, 0, 0, 0, 0)); cyc("br_c1");
        clr_req(4);

        // Squash while multipliers are busy
        do_reset("rst_sq");
        set_req(0, C_MULT); set_req(1, C_MULT);
        push_exp(mk3(2, 0, M1, 1, M2, 0, 0)); cyc("sq_fill");
        clr_req(0); clr_req(1);
        set_req(2, C_MULT); set_req(3, C_ALU); squash = 1'b1;
        push_exp(mk3(0, 0, 0, 0, 0, 0, 0)); cyc("sq_cycle");
        squash = 1'b0;
        push_exp(mk3(2, 2, M1, 3, A1, 0, 0)); cyc("sq_after");
        clr_req(2); clr_req(3);

        // Reset pulse in the middle of load/store activity
        set_req(4, C_LS); set_req(5, C_LS);
        push_exp(mk3(2, 4, L1, 5, L2, 0, 0)); cyc("rst_ls_fill");
        clr_req(4); clr_req(5);
        do_reset("rst_mid");
        set_req(6, C_LS);
        push_exp(mk3(1, 6, L1, 0, 0, 0, 0)); cyc("rst_ls_free");
        clr_req(6);
        set_req(7, C_LS);
        push_exp(mk3(1, 7, L2, 0, 0, 0, 0)); cyc("ls_second");
        clr_req(7);

        // Squash and ls_done together: squash frees both units
        set_req(8, C_LS); squash = 1'b1; ls_done = 2'b01;
        push_exp(mk3(0, 0, 0, 0, 0, 0, 0)); cyc("sq_ls_cycle");
        squash = 1'b0; ls_done = 2'b00; set_req(9, C_LS);
        push_exp(mk3(2, 8, L1, 9, L2, 0, 0)); cyc("sq_ls_after");
        clr_req(8); clr_req(9);

        // Random ALU burst: any 1..3 ALU requests from a fresh pointer all issue in index order
        do_reset("rst_rand");
        begin
            int n;
            int b;
            n = $urandom_range(1, 3);
            b = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) set_req(b + i, C_ALU);
            push_exp(mk3(n, b, A1, b + 1, A2, b + 2, A3)); cyc("rand_alu");
            for (int i = 0; i < n; i++) clr_req(b + i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_issue_arbiter.md
FU_ISSUE_ARBITER -- requirements
Module: fu_issue_arbiter

Interface
REQ-001 SHALL have parameter RS_SIZE, default 2**`RS (16), number of RS entries arbitrated.
REQ-002 SHALL have parameter MULT_LAT, default 4, cycles a multiplier stays occupied per grant.
REQ-003 clock  in  1  system clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low; all state cleared while low.
REQ-005 req_valid  in  RS_SIZE  entry i is ready to issue (both operands ready, not yet issued).
REQ-006 req_class  in  RS_SIZE x 2  per-entry FU class: ALU=0, LS=1, MULT=2, BRANCH=3.
REQ-007 ls_done  in  2  pulse, load/store unit k finished; unit free from next cycle.
REQ-008 squash  in  1  pipeline flush; frees all LS/MULT units next cycle.
REQ-009 issue_valid  out  3  slot s carries a grant this cycle.
REQ-010 issue_idx  out  3 x log2(RS_SIZE)  RS entry granted in slot s.
REQ-011 issue_fu  out  3 x FU_SELECT  concrete unit (ALU_1..3, LS_1..2, MULT_1..2, BRANCH) for slot s.
REQ-012 grant  out  RS_SIZE  one-hot-per-entry mask of entries issued this cycle (RS clears them).

Function
REQ-013 Grants SHALL be combinational from current state and requests (zero-cycle latency); occupancy and pointer SHALL update on the clock edge.
REQ-014 Scan SHALL start at rr_ptr and wrap modulo RS_SIZE; first up to 3 eligible entries in scan order fill slots 0,1,2 in order.
REQ-015 Entry eligible iff req_valid=1 and a unit of its class remains free after earlier slots this cycle.
REQ-016 Per-cycle capacity: ALU 3, LS = number of non-busy LS units, MULT = number of non-busy MULT units, BRANCH 1.
REQ-017 Within a class the lowest-numbered free unit SHALL be assigned first; no unit granted twice in a cycle.
REQ-018 Ineligible entries SHALL be skipped, not block later entries (no head-of-line blocking).
REQ-019 Unused slots SHALL drive issue_valid=0, issue_idx=0, issue_fu=ALU_1.
REQ-020 rr_ptr SHALL advance to (last granted index + 1) mod RS_SIZE when any grant occurs; else hold.
REQ-021 LS unit k busy from edge after grant until edge after ls_done[k]; ls_done on an idle unit ignored.
REQ-022 MULT unit busy exactly MULT_LAT cycles: down-counter loaded with MULT_LAT-1 at grant edge, free when counter is 0.
REQ-023 ALU and BRANCH SHALL carry no occupancy state (single-cycle, pipelined).
REQ-024 squash SHALL suppress all grants in its cycle and clear LS busy flags and MULT counters at the edge; rr_ptr held.
REQ-025 ls_done and a new grant to the same unit in one cycle are impossible (unit busy); ls_done same cycle as squash: squash wins, unit free.

Reset
REQ-026 While reset=0: rr_ptr=0, all LS busy=0, all MULT counters=0; outputs follow REQ-019 with grant=0 when req_valid=0.
REQ-027 Reset asserted mid-operation SHALL abandon all occupancy immediately; no pending ls_done is remembered.

Structure
REQ-028 FU_SELECT enum, FU class encoding and MULT_LAT default SHALL live in the shared sys_defs package.
REQ-029 A sub-module rr_pick3 (rotate, pick first three eligible, un-rotate) is natural; occupancy tracking stays in the top.

Verification
REQ-030 5 ALU requests at entries 0..4, rr_ptr=0 -> slots get 0,1,2 on ALU_1,2,3; rr_ptr=3; next cycle 3,4 granted.
REQ-031 Entries 2,5,9 all MULT, idle -> 2→MULT_1, 5→MULT_2, 9 waits exactly 4 cycles, then gets MULT_1.
REQ-032 Entry 0 LS, entry 1 LS, entry 2 LS -> 0→LS_1, 1→LS_2; 2 waits; ls_done[1] at cycle 5 -> 2→LS_2 at cycle 6.
REQ-033 rr_ptr=14, ALU requests at 15,0,1 -> order 15,0,1; rr_ptr wraps to 2.
REQ-034 Two BRANCH at 3,4 plus ALU at 5 -> 3→BRANCH, 5→ALU_1, 4 next cycle.
REQ-035 MULT busy plus squash -> no grants that cycle; MULT request granted the following cycle; reset pulse mid-LS likewise frees LS.
